nn_layer_sequencer: RTL and testbench
=====================================

# nn_layer_sequencer

Parametrised inference sequencer for NUM_LAYERS fully connected layers with optional ReLU per layer and a final argmax. It drives one shared matrix_multiply engine, one shared relu engine and one argmax engine through start/done handshakes. For each layer it supplies the engine dimensions and a layer index that selects the weight and activation memory banks. It sits between the host start/result logic and the compute engines, and generalises the fixed four-layer controller.

## Interface
- NUM_LAYERS, 4: number of layers, 1..15.
- DIM_W, 10: width of one layer dimension.
- IDX_W, 4: width of the argmax result index.
- clk  in  1: clock, rising edge.
- resetn  in  1: asynchronous, active-low reset.
- start  in  1: request an inference; sampled only in IDLE.
- abort  in  1: synchronous abort; returns to IDLE from any state.
- cfg_k  in  NUM_LAYERS*DIM_W: per-layer input length; layer i occupies bits [i*DIM_W +: DIM_W].
- cfg_n  in  NUM_LAYERS*DIM_W: per-layer output length, same packing.
- cfg_relu_mask  in  NUM_LAYERS: bit i set means run ReLU after layer i.
- mm_start  out  1: one-cycle start pulse to the matrix engine.
- mm_k, mm_n  out  DIM_W each: current layer dimensions; held stable from the pulse until mm_done.
- mm_done  in  1: matrix engine completion.
- relu_start  out  1: one-cycle start pulse to the relu engine.
- relu_d  out  DIM_W: equals the current layer's n.
- relu_done  in  1: relu engine completion.
- layer_idx  out  4: current layer, used for memory bank selection.
- argmax_start  out  1: one-cycle start pulse to the argmax engine.
- argmax_size  out  DIM_W: n of the last layer.
- argmax_done  in  1: argmax engine completion.
- argmax_index  in  IDX_W: argmax engine result.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse at completion, including error completion.
- err  out  1: sticky error flag; a zero dimension was found.
- result_index  out  IDX_W: registered argmax result.
- result_valid  out  1: result_index is valid.
- cycle_count  out  32: cycles per inference; see Configuration.

## Operation
- States: IDLE, MM_ISSUE, MM_WAIT, RELU_ISSUE, RELU_WAIT, ARG_ISSUE, ARG_WAIT, DONE.
- IDLE, start=1:
  - clear err, result_valid and layer_idx;
  - go to MM_ISSUE.
- MM_ISSUE:
  - if cfg_k or cfg_n of the current layer is 0, set err and go to DONE;
  - otherwise pulse mm_start and go to MM_WAIT.
- MM_WAIT, mm_done=1:
  - to RELU_ISSUE if the current layer's mask bit is set;
  - else to MM_ISSUE of layer_idx+1 if this is not the last layer;
  - else to ARG_ISSUE.
- RELU_ISSUE pulses relu_start and goes to RELU_WAIT.
- RELU_WAIT, relu_done=1: to MM_ISSUE of the next layer, or to ARG_ISSUE after the last layer.
- ARG_ISSUE pulses argmax_start and goes to ARG_WAIT.
- ARG_WAIT, argmax_done=1: capture argmax_index into result_index, set result_valid, go to DONE.
- DONE pulses done and returns to IDLE.
- Engine done inputs are ignored in every state except their own WAIT state, including a done that coincides with the issue pulse.
- start while busy is ignored.
- abort:
  - has priority over every transition;
  - next state is IDLE with no done pulse;
  - clears result_valid and leaves err unchanged.
- layer_idx does not wrap; it never exceeds NUM_LAYERS-1.
- Reset values: every output 0; state IDLE.
- Reset in mid-operation behaves exactly like power-up. In-flight engines must be reset by the same resetn.

## Timing
- All outputs are registered.
- start accepted at edge t: MM_ISSUE at t+1, mm_start high during cycle t+1.
- Each handshake costs 2 cycles of overhead: one issue cycle, plus the cycle after done is sampled.
- Total latency is 2 + 2·(layers + ReLU count + 1) cycles plus engine time, with done as the last cycle.
- result_index and result_valid update on the same edge that enters DONE. They hold until the next accepted start.

## Configuration
- NN_SEQ_PERF_EN defined:
  - cycle_count clears on accepted start and increments every busy cycle, saturating at 32'hFFFF_FFFF;
  - it holds after done.
- NN_SEQ_PERF_EN undefined: cycle_count is constant 0 and no counter logic is synthesised.

## Structure
- Shared package nn_pkg holds the state enum and the encodings for NN_MAX_LAYERS and the layer_idx width.
- The cfg field extraction for the current layer is a combinational mux inside the block.
- The perf counter is an optional sub-module, nn_seq_perf_counter, instantiated only under NN_SEQ_PERF_EN.

## Test plan
- NUM_LAYERS=4, dims 784/64, 64/64, 64/32, 32/10, mask 4'b0111, engines reply done after 3 cycles:
  - sequence is mm, relu, mm, relu, mm, relu, mm, argmax;
  - layer_idx runs 0..3, argmax_size=10;
  - argmax_index=7 gives result_index=7, result_valid=1, one done pulse.
- Mask 4'b0000: no relu_start ever issued; four mm_start pulses, then argmax.
- cfg_n of layer 2 = 0: err=1 and done pulses after layer 1 completes; no mm_start for layer 2 and no argmax_start.
- abort asserted in RELU_WAIT of layer 1: IDLE next cycle, no done, result_valid=0; a new start restarts at layer 0.
- Negation of resetn in MM_WAIT: all outputs 0 immediately; start ignored while busy, and a spurious mm_done in IDLE is ignored.
- With NN_SEQ_PERF_EN, engines at 3-cycle latency and the 4-layer run: cycle_count equals the measured start-to-done cycle count. Without it, cycle_count stays 0.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared definitions for the layer sequencer: state encoding, the maximum
// supported layer count and the width of the layer index.
package nn_pkg;

    localparam int NN_MAX_LAYERS = 15;
    localparam int NN_LIDX_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MM_ISSUE,
        ST_MM_WAIT,
        ST_RELU_ISSUE,
        ST_RELU_WAIT,
        ST_ARG_ISSUE,
        ST_ARG_WAIT,
        ST_DONE
    } nn_state_e;

endpackage

// File: rtl/nn_seq_perf_counter.sv
// Saturating 32-bit busy-cycle counter for the layer sequencer.
// Only instantiated when NN_SEQ_PERF_EN is defined.
module nn_seq_perf_counter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    // Clear on an accepted start, otherwise count busy cycles and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 32'd0;
        end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Inference sequencer for NUM_LAYERS fully connected layers: drives the
// shared matrix, relu and argmax engines through start/done handshakes.
// Optional feature: define NN_SEQ_PERF_EN to get a busy-cycle counter on
// cycle_count; otherwise cycle_count is tied to zero.
module nn_layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int DIM_W      = 10,
    parameter int IDX_W      = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic                        abort,
    input  logic [NUM_LAYERS*DIM_W-1:0] cfg_k,
    input  logic [NUM_LAYERS*DIM_W-1:0] cfg_n,
    input  logic [NUM_LAYERS-1:0]       cfg_relu_mask,
    output logic                        mm_start,
    output logic [DIM_W-1:0]            mm_k,
    output logic [DIM_W-1:0]            mm_n,
    input  logic                        mm_done,
    output logic                        relu_start,
    output logic [DIM_W-1:0]            relu_d,
    input  logic                        relu_done,
    output logic [3:0]                  layer_idx,
    output logic                        argmax_start,
    output logic [DIM_W-1:0]            argmax_size,
    input  logic                        argmax_done,
    input  logic [IDX_W-1:0]            argmax_index,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [IDX_W-1:0]            result_index,
    output logic                        result_valid,
    output logic [31:0]                 cycle_count
);

    // Config vectors are zero-padded to the full index range so a 4-bit
    // layer index can select a field without any out-of-range slice.
    localparam int SPAN = 1 << NN_LIDX_W;
    localparam int PAD  = SPAN - NUM_LAYERS;
    localparam logic [NN_LIDX_W-1:0] LAST_LAYER = NN_LIDX_W'(NUM_LAYERS - 1);

    nn_state_e              state_q, state_d;
    logic [NN_LIDX_W-1:0]   layer_q, layer_d;
    logic                   mm_start_q, mm_start_d;
    logic [DIM_W-1:0]       mm_k_q, mm_k_d;
    logic [DIM_W-1:0]       mm_n_q, mm_n_d;
    logic                   relu_start_q, relu_start_d;
    logic [DIM_W-1:0]       relu_d_q, relu_d_d;
    logic                   argmax_start_q, argmax_start_d;
    logic [DIM_W-1:0]       argmax_size_q, argmax_size_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       result_index_q, result_index_d;
    logic                   result_valid_q, result_valid_d;

    logic [SPAN*DIM_W-1:0]  k_pad, n_pad;
    logic [SPAN-1:0]        mask_pad;
    logic [DIM_W-1:0]       cur_k, cur_n, nxt_k, nxt_n;
    logic                   cur_relu, is_last, start_accept;

    assign k_pad    = {{(PAD*DIM_W){1'b0}}, cfg_k};
    assign n_pad    = {{(PAD*DIM_W){1'b0}}, cfg_n};
    assign mask_pad = {{PAD{1'b0}}, cfg_relu_mask};

    // Current-layer fields feed the FSM; next-layer fields feed the output
    // registers so dimensions are valid in the same cycle as mm_start.
    assign cur_k    = k_pad[int'(layer_q)*DIM_W +: DIM_W];
    assign cur_n    = n_pad[int'(layer_q)*DIM_W +: DIM_W];
    assign cur_relu = mask_pad[layer_q];
    assign nxt_k    = k_pad[int'(layer_d)*DIM_W +: DIM_W];
    assign nxt_n    = n_pad[int'(layer_d)*DIM_W +: DIM_W];

    assign is_last      = (layer_q == LAST_LAYER);
    assign start_accept = (state_q == ST_IDLE) && start && !abort;

    // Next-state and status logic; abort overrides every transition.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        layer_d        = layer_q;
        err_d          = err_q;
        result_index_d = result_index_q;
        result_valid_d = result_valid_q;
        argmax_size_d  = argmax_size_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d        = ST_MM_ISSUE;
                    layer_d        = '0;
                    err_d          = 1'b0;
                    result_valid_d = 1'b0;
                    argmax_size_d  = cfg_n[(NUM_LAYERS-1)*DIM_W +: DIM_W];
                end
            end
            ST_MM_ISSUE: begin
                if ((cur_k == '0) || (cur_n == '0)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MM_WAIT;
                end
            end
            ST_MM_WAIT: begin
                if (mm_done) begin
                    if (cur_relu) begin
                        state_d = ST_RELU_ISSUE;
                    end else if (!is_last) begin
                        layer_d = layer_q + 1'b1;
                        state_d = ST_MM_ISSUE;
                    end else begin
                        state_d = ST_ARG_ISSUE;
                    end
                end
            end
            ST_RELU_ISSUE: state_d = ST_RELU_WAIT;
            ST_RELU_WAIT: begin
                if (relu_done) begin
                    if (!is_last) begin
                        layer_d = layer_q + 1'b1;
                        state_d = ST_MM_ISSUE;
                    end else begin
                        state_d = ST_ARG_ISSUE;
                    end
                end
            end
            ST_ARG_ISSUE: state_d = ST_ARG_WAIT;
            ST_ARG_WAIT: begin
                if (argmax_done) begin
                    result_index_d = argmax_index;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d        = ST_IDLE;
            layer_d        = layer_q;
            err_d          = err_q;
            result_index_d = result_index_q;
            result_valid_d = 1'b0;
            argmax_size_d  = argmax_size_q;
        end
    end

    // Registered outputs, derived from the state being entered.
    always_comb begin
        mm_start_d     = (state_d == ST_MM_ISSUE) && (nxt_k != '0) && (nxt_n != '0);
        mm_k_d         = (state_d == ST_MM_ISSUE) ? nxt_k : mm_k_q;
        mm_n_d         = (state_d == ST_MM_ISSUE) ? nxt_n : mm_n_q;
        relu_d_d       = (state_d == ST_MM_ISSUE) ? nxt_n : relu_d_q;
        relu_start_d   = (state_d == ST_RELU_ISSUE);
        argmax_start_d = (state_d == ST_ARG_ISSUE);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            layer_q        <= '0;
            mm_start_q     <= 1'b0;
            mm_k_q         <= '0;
            mm_n_q         <= '0;
            relu_start_q   <= 1'b0;
            relu_d_q       <= '0;
            argmax_start_q <= 1'b0;
            argmax_size_q  <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            result_index_q <= '0;
            result_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q        <= state_d;
            layer_q        <= layer_d;
            mm_start_q     <= mm_start_d;
            mm_k_q         <= mm_k_d;
            mm_n_q         <= mm_n_d;
            relu_start_q   <= relu_start_d;
            relu_d_q       <= relu_d_d;
            argmax_start_q <= argmax_start_d;
            argmax_size_q  <= argmax_size_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            result_index_q <= result_index_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign mm_start     = mm_start_q;
    assign mm_k         = mm_k_q;
    assign mm_n         = mm_n_q;
    assign relu_start   = relu_start_q;
    assign relu_d       = relu_d_q;
    assign layer_idx    = layer_q;
    assign argmax_start = argmax_start_q;
    assign argmax_size  = argmax_size_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign result_index = result_index_q;
    assign result_valid = result_valid_q;

`ifdef NN_SEQ_PERF_EN
    nn_seq_perf_counter u_perf (
        .clk    (clk),
        .resetn (resetn),
        .clear  (start_accept),
        .inc    (busy_q),
        .count  (cycle_count)
    );
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer: a reference model turns each
// layer configuration into the expected list of engine pulses and the
// final done record; a monitor compares every pulse the DUT emits.
module tb_nn_layer_sequencer;

    localparam int NL = 4;
    localparam int DW = 10;
    localparam int IW = 4;

    logic             clk = 1'b0;
    logic             resetn, start, abort;
    logic [NL*DW-1:0] cfg_k, cfg_n;
    logic [NL-1:0]    cfg_relu_mask;
    logic             mm_start, relu_start, argmax_start;
    logic [DW-1:0]    mm_k, mm_n, relu_d, argmax_size;
    logic             mm_done, relu_done, argmax_done;
    logic [3:0]       layer_idx;
    logic [IW-1:0]    argmax_index, result_index;
    logic             busy, done, err, result_valid;
    logic [31:0]      cycle_count;

    always #5 clk = ~clk;

    nn_layer_sequencer #(.NUM_LAYERS(NL), .DIM_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cfg_k(cfg_k), .cfg_n(cfg_n), .cfg_relu_mask(cfg_relu_mask),
        .mm_start(mm_start), .mm_k(mm_k), .mm_n(mm_n), .mm_done(mm_done),
        .relu_start(relu_start), .relu_d(relu_d), .relu_done(relu_done),
        .layer_idx(layer_idx), .argmax_start(argmax_start),
        .argmax_size(argmax_size), .argmax_done(argmax_done),
        .argmax_index(argmax_index), .busy(busy), .done(done), .err(err),
        .result_index(result_index), .result_valid(result_valid),
        .cycle_count(cycle_count)
    );

    typedef enum int {EV_MM, EV_RELU, EV_ARG, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       layer;
        int       a;
        int       b;
        bit       err;
        bit       valid;
        int       idx;
    } ev_t;

    ev_t     exp_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      lk[NL], ln[NL];
    bit [NL-1:0] lmask;
    int      arg_val, lat, rst_epoch, spur_cnt;
    bit      early;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: walk the layers in order, stop on a zero dimension.
    function automatic void build_expect();
        for (int i = 0; i < NL; i++) begin
            if (lk[i] == 0 || ln[i] == 0) begin
                exp_q.push_back('{kind: EV_DONE, layer: i, a: 0, b: 0, err: 1'b1, valid: 1'b0, idx: 0});
                return;
            end
            exp_q.push_back('{kind: EV_MM, layer: i, a: lk[i], b: ln[i], err: 1'b0, valid: 1'b0, idx: 0});
            if (lmask[i])
                exp_q.push_back('{kind: EV_RELU, layer: i, a: ln[i], b: 0, err: 1'b0, valid: 1'b0, idx: 0});
        end
        exp_q.push_back('{kind: EV_ARG, layer: NL-1, a: ln[NL-1], b: 0, err: 1'b0, valid: 1'b0, idx: 0});
        exp_q.push_back('{kind: EV_DONE, layer: 0, a: 0, b: 0, err: 1'b0, valid: 1'b1, idx: arg_val});
    endfunction

    task automatic apply_cfg();
        for (int i = 0; i < NL; i++) begin
            cfg_k[i*DW +: DW] = DW'(lk[i]);
            cfg_n[i*DW +: DW] = DW'(ln[i]);
        end
        cfg_relu_mask = lmask;
    endtask

    task automatic mon_take(input ev_kind_e k);
        ev_t e;
        check("pulse_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("event_kind", int'(k), int'(e.kind));
        case (k)
            EV_MM: begin
                check("mm_layer", layer_idx, e.layer);
                check("mm_k", mm_k, e.a);
                check("mm_n", mm_n, e.b);
            end
            EV_RELU: begin
                check("relu_layer", layer_idx, e.layer);
                check("relu_d", relu_d, e.a);
            end
            EV_ARG: check("argmax_size", argmax_size, e.a);
            default: begin
                check("done_err", err, e.err);
                check("done_result_valid", result_valid, e.valid);
                if (e.valid) check("done_result_index", result_index, e.idx);
            end
        endcase
    endtask

    // Monitor: every outgoing pulse consumes one expected event.
    initial begin
        forever begin
            @(negedge clk);
            if (mm_start)     mon_take(EV_MM);
            if (relu_start)   mon_take(EV_RELU);
            if (argmax_start) mon_take(EV_ARG);
            if (done)         mon_take(EV_DONE);
        end
    end

    // Matrix engine model; optionally raises done during the issue cycle too,
    // and can emit a spurious done on request.
    initial begin
        int ep, seen;
        seen = 0;
        mm_done = 1'b0;
        @(negedge clk);
        forever begin
            if (mm_start) begin
                ep = rst_epoch;
                if (early) begin
                    mm_done = 1'b1;
                    @(negedge clk);
                    mm_done = 1'b0;
                    repeat (lat - 2) @(negedge clk);
                end else begin
                    repeat (lat - 1) @(negedge clk);
                end
                if (ep == rst_epoch) mm_done = 1'b1;
                @(negedge clk);
                mm_done = 1'b0;
            end else begin
                if (seen != spur_cnt) begin
                    seen = spur_cnt;
                    mm_done = 1'b1;
                end
                @(negedge clk);
                mm_done = 1'b0;
            end
        end
    end

    // Relu engine model.
    initial begin
        int ep;
        relu_done = 1'b0;
        @(negedge clk);
        forever begin
            if (relu_start) begin
                ep = rst_epoch;
                if (early) begin
                    relu_done = 1'b1;
                    @(negedge clk);
                    relu_done = 1'b0;
                    repeat (lat - 2) @(negedge clk);
                end else begin
                    repeat (lat - 1) @(negedge clk);
                end
                if (ep == rst_epoch) relu_done = 1'b1;
                @(negedge clk);
                relu_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Argmax engine model; the index is only meaningful alongside done.
    initial begin
        int ep;
        argmax_done  = 1'b0;
        argmax_index = '0;
        @(negedge clk);
        forever begin
            if (argmax_start) begin
                ep = rst_epoch;
                repeat (lat - 1) @(negedge clk);
                if (ep == rst_epoch) begin
                    argmax_done  = 1'b1;
                    argmax_index = IW'(arg_val);
                end
                @(negedge clk);
                argmax_done  = 1'b0;
                argmax_index = IW'($urandom);
            end else begin
                @(negedge clk);
            end
        end
    end

    // One full inference; optionally pokes start while busy.
    task automatic do_run(input bit poke);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        build_expect();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            start = poke && (i == 3);
            if (busy) cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        @(negedge clk);
        check("idle_after_done", busy, 0);
`ifdef NN_SEQ_PERF_EN
        check("cycle_count", cycle_count, cyc);
`else
        check("cycle_count", cycle_count, 0);
`endif
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic default_cfg();
        lk = '{784, 64, 64, 32};
        ln = '{64, 64, 32, 10};
        lmask = 4'b0111;
        lat = 3;
        early = 1'b0;
        arg_val = 7;
        apply_cfg();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        resetn = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        rst_epoch = 0;
        spur_cnt = 0;
        default_cfg();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_index", result_index, 0);
        check("rst_layer_idx", layer_idx, 0);
        check("rst_mm_start", mm_start, 0);
        check("rst_cycle_count", cycle_count, 0);
        resetn = 1'b1;

        // Reference network with ReLU on the first three layers.
        do_run(1'b0);
        check("ref_result_index", result_index, 7);
        check("ref_result_valid", result_valid, 1);
        check("ref_err", err, 0);

        // No ReLU at all, with a start attempt while busy.
        lmask = 4'b0000;
        apply_cfg();
        do_run(1'b1);

        // Zero output length on layer 2 ends with err after layer 1.
        lmask = 4'b0111;
        ln[2] = 0;
        apply_cfg();
        do_run(1'b0);
        check("zero_dim_err", err, 1);
        check("zero_dim_valid", result_valid, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_keeps_err", err, 1);

        // Abort while waiting on the relu engine of layer 1.
        default_cfg();
        build_expect();
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (relu_start && layer_idx == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_relu_l1", found, 1);
        @(negedge clk);
        abort = 1'b1;
        exp_q.delete();
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", busy, 0);
        check("abort_no_done", done, 0);
        check("abort_valid", result_valid, 0);
        repeat (10) @(negedge clk);
        do_run(1'b0);

        // Reset asserted in the middle of layer 1's matrix wait.
        build_expect();
        @(negedge clk);
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mm_start && layer_idx == 4'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("reach_mm_l1", found, 1);
        @(negedge clk);
        resetn = 1'b0;
        rst_epoch++;
        exp_q.delete();
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_layer_idx", layer_idx, 0);
        check("midrst_mm_k", mm_k, 0);
        check("midrst_argmax_size", argmax_size, 0);
        check("midrst_result_valid", result_valid, 0);
        check("midrst_cycle_count", cycle_count, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        spur_cnt++;
        repeat (6) @(negedge clk);
        check("spurious_mm_done_ignored", busy, 0);

        // Randomised networks, engine latencies and early engine dones.
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < NL; i++) begin
                lk[i] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 1023));
                ln[i] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 1023));
            end
            lmask   = NL'($urandom);
            lat     = int'($urandom_range(2, 5));
            early   = 1'($urandom);
            arg_val = int'($urandom_range(0, 15));
            apply_cfg();
            do_run(1'($urandom));
        end

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
